// File: rtl/main_fsm.sv
// ============================================================================
//  Module      : main_fsm
//  Description : Multi-cycle sequencer for the ARM datapath. It walks each
//                instruction through fetch/decode/execute/memory/writeback,
//                stalls on MemReady, traps on illegal opcodes and counts
//                retired instructions.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrRetired
);

    localparam logic [3:0] c_ST_FETCH  = 4'd0;
    localparam logic [3:0] c_ST_DECODE = 4'd1;
    localparam logic [3:0] c_ST_MEMADR = 4'd2;
    localparam logic [3:0] c_ST_MEMRD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB  = 4'd4;
    localparam logic [3:0] c_ST_MEMWR  = 4'd5;
    localparam logic [3:0] c_ST_EXECR  = 4'd6;
    localparam logic [3:0] c_ST_EXECI  = 4'd7;
    localparam logic [3:0] c_ST_ALUWB  = 4'd8;
    localparam logic [3:0] c_ST_BRANCH = 4'd9;
    localparam logic [3:0] c_ST_TRAP   = 4'd10;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_next;
    logic             w_retire;

    // Funct[4:1] belong to the ALU decoder, not to sequencing.
    logic w_unused;
    assign w_unused = &{1'b0, Funct[4:1]};

    always_comb begin
        w_next   = c_ST_FETCH;
        w_retire = 1'b0;
        case (r_state)
            c_ST_FETCH:  w_next = MemReady ? c_ST_DECODE : c_ST_FETCH;
            c_ST_DECODE: begin
                case (Op)
                    2'b00:   w_next = Funct[5] ? c_ST_EXECI : c_ST_EXECR;
                    2'b01:   w_next = c_ST_MEMADR;
                    2'b10:   w_next = c_ST_BRANCH;
                    default: w_next = c_ST_TRAP;
                endcase
            end
            c_ST_MEMADR: w_next = Funct[0] ? c_ST_MEMRD : c_ST_MEMWR;
            c_ST_MEMRD:  w_next = MemReady ? c_ST_MEMWB : c_ST_MEMRD;
            c_ST_MEMWR: begin
                w_next   = MemReady ? c_ST_FETCH : c_ST_MEMWR;
                w_retire = MemReady;
            end
            c_ST_EXECR:  w_next = c_ST_ALUWB;
            c_ST_EXECI:  w_next = c_ST_ALUWB;
            c_ST_MEMWB, c_ST_ALUWB, c_ST_BRANCH: begin
                w_next   = c_ST_FETCH;
                w_retire = 1'b1;
            end
            c_ST_TRAP:   w_next = c_ST_TRAP;
            default:     w_next = c_ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_ST_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

    // Write/fetch enables are suppressed for the whole cycle reset is held low.
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        Illegal   = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady & reset;
                NextPC    = MemReady & reset;
            end
            c_ST_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            c_ST_MEMADR: ALUSrcB = 2'b01;
            c_ST_MEMRD:  AdrSrc  = 1'b1;
            c_ST_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = reset;
            end
            c_ST_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = reset;
            end
            c_ST_EXECR:  ALUOp = 1'b1;
            c_ST_EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            c_ST_ALUWB:  RegW = reset;
            c_ST_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = reset;
            end
            c_ST_TRAP:   Illegal = 1'b1;
            default: ;
        endcase
    end

    assign State        = r_state;
    assign InstrRetired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_main_fsm.sv
// ============================================================================
//  Module      : tb_main_fsm
//  Description : Randomised instruction stream for main_fsm; an instruction-
//                level model queues per-cycle expectations for a monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_main_fsm;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [3:0]       st;
        logic [12:0]      ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             MemReady;
    logic             IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp;
    logic             RegW, MemW, Branch, Illegal;
    logic [1:0]       ALUSrcB, ResultSrc;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrRetired;

    int               checks = 0;
    int               errors = 0;
    exp_t             exp_q[$];
    logic [CNT_W-1:0] model_cnt = '0;

    always #5 clk = ~clk;

    main_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .Illegal(Illegal), .State(State),
        .InstrRetired(InstrRetired)
    );

    // Control word order: IRWrite NextPC AdrSrc ALUSrcA ALUSrcB ResultSrc ALUOp RegW MemW Branch Illegal
    function automatic exp_t make_exp(input logic [3:0] st, input logic mr, input logic rst,
                                      input logic [CNT_W-1:0] cnt);
        logic irw, npc, adr, sa, aop, rw, mw, br, ill;
        logic [1:0] sb, rs;
        exp_t e;
        {irw, npc, adr, sa, aop, rw, mw, br, ill} = '0;
        sb = 2'b00;
        rs = 2'b00;
        case (st)
            4'd0:  begin sa = 1; sb = 2; rs = 2; irw = mr; npc = mr; end
            4'd1:  begin sa = 1; sb = 2; rs = 2; end
            4'd2:  sb = 1;
            4'd3:  adr = 1;
            4'd4:  begin rs = 1; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  aop = 1;
            4'd7:  begin sb = 1; aop = 1; end
            4'd8:  rw = 1;
            4'd9:  begin sb = 1; rs = 2; br = 1; end
            4'd10: ill = 1;
            default: ;
        endcase
        if (!rst) begin
            {irw, npc, rw, mw, br} = '0;
        end
        e.st  = st;
        e.ctl = {irw, npc, adr, sa, sb, rs, aop, rw, mw, br, ill};
        e.cnt = cnt;
        return e;
    endfunction

    // One clock cycle: apply inputs just after the edge and queue what the DUT must show.
    task automatic step(input logic mr, input logic rst, input logic [3:0] st);
        MemReady = mr;
        reset    = rst;
        exp_q.push_back(make_exp(st, mr, rst, model_cnt));
        @(posedge clk);
        #1;
        if (!rst) model_cnt = '0;
    endtask

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Fetch, decode and execute one legal instruction; fw/w are memory wait cycles.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input int fw, input int w);
        Op    = op;
        Funct = fn;
        repeat (fw) step(1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd0);
        step(rnd_bit(), 1'b1, 4'd1);
        case (op)
            2'b00: begin
                step(rnd_bit(), 1'b1, fn[5] ? 4'd7 : 4'd6);
                step(rnd_bit(), 1'b1, 4'd8);
            end
            2'b01: begin
                step(rnd_bit(), 1'b1, 4'd2);
                if (fn[0]) begin
                    repeat (w) step(1'b0, 1'b1, 4'd3);
                    step(1'b1, 1'b1, 4'd3);
                    step(rnd_bit(), 1'b1, 4'd4);
                end else begin
                    repeat (w) step(1'b0, 1'b1, 4'd5);
                    step(1'b1, 1'b1, 4'd5);
                end
            end
            default: step(rnd_bit(), 1'b1, 4'd9);
        endcase
        model_cnt = model_cnt + 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 3;
            if (State !== e.st) begin
                errors = errors + 1;
                $display("FAIL state: got %0d expected %0d at %0t", State, e.st, $time);
            end
            if ({IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, Illegal}
                !== e.ctl) begin
                errors = errors + 1;
                $display("FAIL controls (state %0d): got %b expected %b at %0t", e.st,
                         {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW,
                          Branch, Illegal}, e.ctl, $time);
            end
            if (InstrRetired !== e.cnt) begin
                errors = errors + 1;
                $display("FAIL retired: got %0d expected %0d at %0t", InstrRetired, e.cnt, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        reset    = 1'b0;
        MemReady = 1'b1;
        Op       = 2'b00;
        Funct    = 6'b000000;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 4'd0);

        run_instr(2'b00, 6'b000100, 0, 0);   // ADD register
        run_instr(2'b01, 6'b011001, 0, 3);   // LDR, three wait cycles
        run_instr(2'b01, 6'b011000, 0, 2);   // STR, two wait cycles
        run_instr(2'b00, 6'b101000, 5, 0);   // fetch stalled five cycles
        run_instr(2'b10, 6'b000000, 0, 0);   // branch

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 2));
            fn = 6'($urandom);
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        // Reset while an LDR is waiting in MEMRD: aborted, counter cleared.
        Op    = 2'b01;
        Funct = 6'b011001;
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd1);
        step(1'b0, 1'b1, 4'd2);
        step(1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b0, 4'd3);
        run_instr(2'b00, 6'b000100, 0, 0);

        // Illegal opcode traps until reset.
        Op = 2'b11;
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd1);
        for (int i = 0; i < 6; i++) step(rnd_bit(), 1'b1, 4'd10);
        step(1'b1, 1'b0, 4'd10);
        run_instr(2'b10, 6'b000000, 0, 0);
        step(1'b0, 1'b1, 4'd0);

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
